// File: rtl/legv8_ctrl_pkg.sv
// Shared constants for the LEGv8 control sequencer: FSM states, instruction
// classes, ALU function codes, opcodes and status flag positions.
package legv8_ctrl_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_DECODE   = 3'd1;
   localparam logic [2:0] ST_EXEC     = 3'd2;
   localparam logic [2:0] ST_MEM_ADDR = 3'd3;
   localparam logic [2:0] ST_MEM_WAIT = 3'd4;
   localparam logic [2:0] ST_BRANCH   = 3'd5;
   localparam logic [2:0] ST_CBZ_TAKE = 3'd6;
   localparam logic [2:0] ST_TRAP     = 3'd7;

   typedef enum logic [2:0] {
      CLS_R, CLS_I, CLS_LD, CLS_ST, CLS_CBZ, CLS_B, CLS_TRAP
   } instr_class_e;

   localparam logic [4:0] FS_AND = 5'b00000;
   localparam logic [4:0] FS_ORR = 5'b00100;
   localparam logic [4:0] FS_ADD = 5'b01000;
   localparam logic [4:0] FS_SUB = 5'b01001;
   localparam logic [4:0] FS_EOR = 5'b01100;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_EOR  = 11'b11001010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [9:0]  OP_ADDI = 10'b1001000100;
   localparam logic [9:0]  OP_SUBI = 10'b1101000100;
   localparam logic [7:0]  OP_CBZ  = 8'b10110100;
   localparam logic [5:0]  OP_B    = 6'b000101;

   localparam int ST_Z = 0;
   localparam int ST_N = 1;
   localparam int ST_C = 2;
   localparam int ST_V = 3;

endpackage

// File: rtl/legv8_instr_decode.sv
// Combinational decode of the latched instruction register into class,
// ALU function, register fields and the extended immediate / branch offset.
module legv8_instr_decode
   import legv8_ctrl_pkg::*;
(
   input  logic [31:0]  ir,
   output instr_class_e cls,
   output logic [4:0]   fs,
   output logic         cin,
   output logic [4:0]   rd,
   output logic [4:0]   rn,
   output logic [4:0]   rm,
   output logic [4:0]   rt,
   output logic [63:0]  imm,
   output logic [63:0]  off
);

   assign rd = ir[4:0];
   assign rt = ir[4:0];
   assign rn = ir[9:5];
   assign rm = ir[20:16];

   // Longest opcode field is matched first so shorter prefixes never shadow it.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
      cls = CLS_TRAP;
      fs  = FS_ADD;
      cin = 1'b0;
      imm = '0;
      off = '0;
      if (ir[31:21] == OP_ADD) begin
         cls = CLS_R;
      end else if (ir[31:21] == OP_SUB) begin
         cls = CLS_R;
         fs  = FS_SUB;
         cin = 1'b1;
      end else if (ir[31:21] == OP_AND) begin
         cls = CLS_R;
         fs  = FS_AND;
      end else if (ir[31:21] == OP_ORR) begin
         cls = CLS_R;
         fs  = FS_ORR;
      end else if (ir[31:21] == OP_EOR) begin
         cls = CLS_R;
         fs  = FS_EOR;
      end else if (ir[31:21] == OP_LDUR || ir[31:21] == OP_STUR) begin
         cls = (ir[31:21] == OP_LDUR) ? CLS_LD : CLS_ST;
         imm = {{55{ir[20]}}, ir[20:12]};
      end else if (ir[31:22] == OP_ADDI) begin
         cls = CLS_I;
         imm = {52'd0, ir[21:10]};
      end else if (ir[31:22] == OP_SUBI) begin
         cls = CLS_I;
         fs  = FS_SUB;
         cin = 1'b1;
         imm = {52'd0, ir[21:10]};
      end else if (ir[31:24] == OP_CBZ) begin
         cls = CLS_CBZ;
         off = {{43{ir[23]}}, ir[23:5], 2'b00};
      end else if (ir[31:26] == OP_B) begin
         cls = CLS_B;
         off = {{36{ir[25]}}, ir[25:0], 2'b00};
      end
   end

endmodule

// File: rtl/legv8_control_sequencer.sv
// Multi-cycle LEGv8 control unit: accepts one instruction per handshake and
// sequences ALU, memory and branch control words from state + latched IR.
module legv8_control_sequencer
   import legv8_ctrl_pkg::*;
#(
   parameter logic [4:0] XZR_IDX = 5'd31,
   parameter logic [7:0] MEM_TMO = 8'd255
)(
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [3:0]  status,
   output logic [4:0]  SA,
   output logic [4:0]  SB,
   output logic [4:0]  DA,
   output logic [4:0]  FS,
   output logic        Cin,
   output logic        W,
   output logic        selbork,
   output logic [63:0] k,
   output logic        triSelBtoD,
   output logic        triSelFtoD,
   output logic        mem_addr_ld,
   output logic        mem_req,
   output logic        mem_we,
   input  logic        mem_ack,
   output logic        pc_load,
   output logic [63:0] pc_offset,
   output logic        illegal
);

   logic [2:0]   state;
   logic [31:0]  ir;
   logic [7:0]   cnt;

   instr_class_e cls;
   logic [4:0]   dec_fs, rd, rn, rm, rt;
   logic         dec_cin;
   logic [63:0]  imm, off;
   logic         timed_out;
   logic         unused_status;

   assign unused_status = ^status[ST_V:ST_N];
   assign timed_out     = (cnt == MEM_TMO);

   legv8_instr_decode u_decode (
      .ir  (ir),
      .cls (cls),
      .fs  (dec_fs),
      .cin (dec_cin),
      .rd  (rd),
      .rn  (rn),
      .rm  (rm),
      .rt  (rt),
      .imm (imm),
      .off (off)
   );

   always_ff @(posedge clock or negedge reset) begin
      // NOTE: IR and the timeout counter are reset too, so a fresh IDLE never shows stale fields.
      if (!reset) begin
         state <= ST_IDLE;
         ir    <= '0;
         cnt   <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register update tied to the same edge.
         case (state)
            ST_IDLE: begin
               if (instr_valid) begin
                  ir    <= instr;
                  state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               case (cls)
                  CLS_R, CLS_I:    state <= ST_EXEC;
                  CLS_LD, CLS_ST:  state <= ST_MEM_ADDR;
                  CLS_CBZ, CLS_B:  state <= ST_BRANCH;
                  default:         state <= ST_TRAP;
               endcase
            end
            ST_MEM_ADDR: begin
               cnt   <= '0;
               state <= ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
               if (timed_out || mem_ack) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_BRANCH: begin
               state <= (cls == CLS_CBZ && status[ST_Z]) ? ST_CBZ_TAKE : ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      instr_ready = (state == ST_IDLE);
      SA          = '0;
      SB          = '0;
      DA          = '0;
      FS          = '0;
      Cin         = 1'b0;
      W           = 1'b0;
      selbork     = 1'b0;
      k           = '0;
      triSelBtoD  = 1'b0;
      triSelFtoD  = 1'b0;
      mem_addr_ld = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      pc_load     = 1'b0;
      pc_offset   = '0;
      illegal     = 1'b0;
      case (state)
         ST_EXEC: begin
            SA  = rn;
            DA  = rd;
            W   = (rd != XZR_IDX);
            FS  = dec_fs;
            Cin = dec_cin;
            if (cls == CLS_I) begin
               selbork = 1'b1;
               k       = imm;
            end else begin
               SB = rm;
            end
         end
         ST_MEM_ADDR: begin
            SA          = rn;
            selbork     = 1'b1;
            k           = imm;
            FS          = FS_ADD;
            triSelFtoD  = 1'b1;
            mem_addr_ld = 1'b1;
         end
         ST_MEM_WAIT: begin
            mem_req = 1'b1;
            mem_we  = (cls == CLS_ST);
            illegal = timed_out;
            if (cls == CLS_ST) begin
               SB         = rt;
               triSelBtoD = 1'b1;
            end else begin
               DA = rt;
               W  = mem_ack && !timed_out && (rt != XZR_IDX);
            end
         end
         ST_BRANCH: begin
            if (cls == CLS_B) begin
               pc_load   = 1'b1;
               pc_offset = off;
            end else begin
               SA      = rt;
               selbork = 1'b1;
               FS      = FS_ADD;
            end
         end
         ST_CBZ_TAKE: begin
            pc_load   = 1'b1;
            pc_offset = off;
         end
         ST_TRAP: illegal = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_legv8_control_sequencer.sv
// Self-checking bench for legv8_control_sequencer: directed cases plus random
// instructions compared cycle by cycle against an instruction-level model.
module tb_legv8_control_sequencer;

   localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_ORR = 3, K_EOR = 4, K_ADDI = 5,
                  K_SUBI = 6, K_LDUR = 7, K_STUR = 8, K_CBZ = 9, K_B = 10, K_BAD = 11;

   // Opcode table, longest field first.
   localparam int OP_W [11] = '{11, 11, 11, 11, 11, 11, 11, 10, 10, 8, 6};
   localparam int OP_P [11] = '{'b10001011000, 'b11001011000, 'b10001010000, 'b10101010000,
                                'b11001010000, 'b11111000010, 'b11111000000, 'b1001000100,
                                'b1101000100, 'b10110100, 'b000101};
   localparam int OP_K [11] = '{K_ADD, K_SUB, K_AND, K_ORR, K_EOR, K_LDUR, K_STUR,
                                K_ADDI, K_SUBI, K_CBZ, K_B};

   typedef struct packed {
      logic        instr_ready;
      logic [4:0]  sa, sb, da, fs;
      logic        cin, w, selbork;
      logic [63:0] k;
      logic        tri_b, tri_f, mem_addr_ld, mem_req, mem_we, pc_load;
      logic [63:0] pc_offset;
      logic        illegal;
   } obs_t;

   typedef struct packed {
      logic [3:0]  kind;
      logic [4:0]  rd, rn, rm, fs;
      logic        cin;
      logic [63:0] imm, off;
   } dec_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] instr = '0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [3:0]  status = '0;
   logic [4:0]  SA, SB, DA, FS;
   logic        Cin, W, selbork;
   logic [63:0] k, pc_offset;
   logic        triSelBtoD, triSelFtoD, mem_addr_ld, mem_req, mem_we;
   logic        mem_ack = 1'b0;
   logic        pc_load, illegal;

   int tests = 0;
   int fails = 0;
   obs_t obs;

   always #5 clock = ~clock;

   legv8_control_sequencer dut (
      .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .status(status), .SA(SA), .SB(SB), .DA(DA), .FS(FS),
      .Cin(Cin), .W(W), .selbork(selbork), .k(k), .triSelBtoD(triSelBtoD),
      .triSelFtoD(triSelFtoD), .mem_addr_ld(mem_addr_ld), .mem_req(mem_req),
      .mem_we(mem_we), .mem_ack(mem_ack), .pc_load(pc_load), .pc_offset(pc_offset),
      .illegal(illegal)
   );

   assign obs = {instr_ready, SA, SB, DA, FS, Cin, W, selbork, k, triSelBtoD, triSelFtoD,
                 mem_addr_ld, mem_req, mem_we, pc_load, pc_offset, illegal};

   task automatic check(input string tag, input obs_t exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic dec_t ref_decode(input logic [31:0] word);
      dec_t d;
      d = '0;
      d.kind = K_BAD;
      for (int i = 0; i < 11; i++)
         if (d.kind == K_BAD && (word >> (32 - OP_W[i])) == 32'(OP_P[i]))
            d.kind = 4'(OP_K[i]);
      d.rd = word[4:0];
      d.rn = word[9:5];
      d.rm = word[20:16];
      case (int'(d.kind))
         K_SUB, K_SUBI: begin d.fs = 5'b01001; d.cin = 1'b1; end
         K_AND:         d.fs = 5'b00000;
         K_ORR:         d.fs = 5'b00100;
         K_EOR:         d.fs = 5'b01100;
         default:       d.fs = 5'b01000;
      endcase
      if (d.kind == K_ADDI || d.kind == K_SUBI) d.imm = 64'(word[21:10]);
      if (d.kind == K_LDUR || d.kind == K_STUR) d.imm = 64'(longint'($signed(word[20:12])));
      if (d.kind == K_CBZ) d.off = 64'(longint'($signed(word[23:5])) * 4);
      if (d.kind == K_B)   d.off = 64'(longint'($signed(word[25:0])) * 4);
      return d;
   endfunction

   function automatic obs_t exp_idle();
      obs_t e = '0;
      e.instr_ready = 1'b1;
      return e;
   endfunction

   function automatic obs_t exp_exec(input dec_t d);
      obs_t e = '0;
      e.sa = d.rn; e.da = d.rd; e.w = (d.rd != 5'd31); e.fs = d.fs; e.cin = d.cin;
      if (d.kind == K_ADDI || d.kind == K_SUBI) begin e.selbork = 1'b1; e.k = d.imm; end
      else e.sb = d.rm;
      return e;
   endfunction

   function automatic obs_t exp_addr(input dec_t d);
      obs_t e = '0;
      e.sa = d.rn; e.selbork = 1'b1; e.k = d.imm; e.fs = 5'b01000;
      e.tri_f = 1'b1; e.mem_addr_ld = 1'b1;
      return e;
   endfunction

   function automatic obs_t exp_wait(input dec_t d, input logic ack, input logic tmo);
      obs_t e = '0;
      e.mem_req = 1'b1; e.illegal = tmo;
      if (d.kind == K_STUR) begin e.mem_we = 1'b1; e.sb = d.rd; e.tri_b = 1'b1; end
      else begin e.da = d.rd; e.w = ack && !tmo && (d.rd != 5'd31); end
      return e;
   endfunction

   function automatic obs_t exp_branch(input dec_t d);
      obs_t e = '0;
      if (d.kind == K_B) begin e.pc_load = 1'b1; e.pc_offset = d.off; end
      else begin e.sa = d.rd; e.selbork = 1'b1; e.fs = 5'b01000; end
      return e;
   endfunction

   // ack_delay < 0 means mem_ack never arrives.
   task automatic run_instr(input string name, input logic [31:0] word, input int ack_delay,
                            input logic z);
      dec_t d;
      obs_t e;
      d = ref_decode(word);
      @(negedge clock); instr = word; instr_valid = 1'b1; mem_ack = 1'b0;
      #1 check({name, ".idle"}, exp_idle());
      // A second instruction offered while busy must be ignored.
      @(negedge clock); instr = $urandom;
      #1 check({name, ".decode"}, '0);
      @(negedge clock); instr_valid = 1'b0; instr = '0;
      status = {3'($urandom), z};
      #1;
      case (int'(d.kind))
         K_LDUR, K_STUR: begin
            check({name, ".mem_addr"}, exp_addr(d));
            for (int c = 0; c < 256; c++) begin
               @(negedge clock);
               mem_ack = (c == ack_delay);
               #1 check({name, ".mem_wait"}, exp_wait(d, mem_ack, c == 255));
               if (mem_ack || c == 255) break;
            end
            @(negedge clock); mem_ack = 1'b0;
            #1;
         end
         K_CBZ, K_B: begin
            check({name, ".branch"}, exp_branch(d));
            @(negedge clock);
            #1;
            if (d.kind == K_CBZ && z) begin
               e = '0; e.pc_load = 1'b1; e.pc_offset = d.off;
               check({name, ".cbz_take"}, e);
               @(negedge clock);
               #1;
            end
         end
         K_BAD: begin
            e = '0; e.illegal = 1'b1;
            check({name, ".trap"}, e);
            @(negedge clock);
            #1;
         end
         default: begin
            check({name, ".exec"}, exp_exec(d));
            @(negedge clock);
            #1;
         end
      endcase
      check({name, ".back_idle"}, exp_idle());
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      int sel;
      r = $urandom;
      sel = $urandom_range(0, 11);
      if (sel < 7) r[31:21] = 11'(OP_P[sel]);
      else if (sel < 9) r[31:22] = 10'(OP_P[sel]);
      else if (sel == 9) r[31:24] = 8'(OP_P[9]);
      else if (sel == 10) r[31:26] = 6'(OP_P[10]);
      return r;
   endfunction

   initial begin
      obs_t e;
      logic [31:0] w;
      #2 check("reset_state", exp_idle());
      @(negedge clock); reset = 1'b1;

      run_instr("add_x1_x2_x3", 32'h8B030041, 0, 1'b0);
      run_instr("subi_x5", {10'b1101000100, 12'd16, 5'd5, 5'd5}, 0, 1'b0);
      run_instr("subi_xzr", {10'b1101000100, 12'd16, 5'd5, 5'd31}, 0, 1'b0);
      run_instr("ldur_x4_m8", {11'b11111000010, 9'h1F8, 2'b00, 5'd6, 5'd4}, 3, 1'b0);
      run_instr("cbz_taken", {8'b10110100, 19'h7FFFC, 5'd7}, 0, 1'b1);
      run_instr("cbz_not_taken", {8'b10110100, 19'h7FFFC, 5'd7}, 0, 1'b0);
      run_instr("b_fwd", {6'b000101, 26'h0000123}, 0, 1'b0);
      run_instr("stur_timeout", {11'b11111000000, 9'h010, 2'b00, 5'd2, 5'd9}, -1, 1'b0);
      run_instr("opcode_zero", 32'h0000_0000, 0, 1'b0);

      // Asynchronous reset in the middle of a memory wait.
      w = {11'b11111000000, 9'h004, 2'b00, 5'd3, 5'd8};
      @(negedge clock); instr = w; instr_valid = 1'b1;
      @(negedge clock); instr_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      #1 check("pre_reset_wait", exp_wait(ref_decode(w), 1'b0, 1'b0));
      #2 reset = 1'b0;
      #1 check("async_reset", exp_idle());
      @(negedge clock); reset = 1'b1;
      #1 check("after_reset", exp_idle());

      for (int i = 0; i < 40; i++)
         run_instr($sformatf("rand%0d", i), rand_instr(), int'($urandom_range(0, 5)),
                   1'($urandom));
      for (int i = 0; i < 8; i++)
         run_instr($sformatf("raw%0d", i), $urandom, int'($urandom_range(0, 3)), 1'($urandom));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
